// File: rtl/lsu_mem.sv
// Memory-access stage: registers ALU results toward writeback, runs one req/ack data-bus
// transaction per load/store and formats load data. `define LSU_BUS_TIMEOUT_EN adds an ack-wait timeout.
module lsu_mem #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_reg_waddr,
    input  logic              ex_reg_we,
    input  logic [31:0]       ex_reg_wdata,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [2:0]        ex_mem_op,
    input  logic [31:0]       ex_store_data,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_reg_waddr,
    output logic              wb_reg_we,
    output logic [31:0]       wb_reg_wdata,
    output logic              misalign_o,
    output logic              bus_err_o
);
    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        offs;
    logic              is_mem, is_store, is_half, is_word, misaligned, accept, tmo_hit;
    logic [3:0]        be_byte, be_req;
    logic [31:0]       wdata_req, load_data;
    logic [7:0]        rd_byte [4];
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    logic              dbus_we_reg, dbus_we_next;
    logic [ADDR_W-1:0] dbus_addr_reg, dbus_addr_next;
    logic [3:0]        dbus_be_reg, dbus_be_next;
    logic [31:0]       dbus_wdata_reg, dbus_wdata_next;
    logic              wb_valid_reg, wb_valid_next;
    logic [4:0]        wb_waddr_reg, wb_waddr_next;
    logic              wb_we_reg, wb_we_next;
    logic [31:0]       wb_wdata_reg, wb_wdata_next;
    logic              misalign_reg, misalign_next;
    logic              bus_err_reg, bus_err_next;
    logic [2:0]        op_reg, op_next;
    logic [1:0]        offs_reg, offs_next;
    logic [4:0]        pend_waddr_reg, pend_waddr_next;
    logic              pend_we_reg, pend_we_next;

    assign addr       = ex_reg_wdata[ADDR_W-1:0];
    assign offs       = addr[1:0];
    assign is_mem     = ex_mem_rd | ex_mem_wr;
    assign is_store   = ex_mem_wr;
    // op[1] set means word size, which also absorbs the unused codes 011/110/111
    assign is_word    = ex_mem_op[1];
    assign is_half    = !ex_mem_op[1] && ex_mem_op[0];
    assign misaligned = (is_half && offs[0]) || (is_word && offs != 2'b00);
    assign ex_ready   = (state_reg == IDLE) && !rst;
    assign accept     = ex_valid && ex_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be_byte[gi] = (offs == 2'(gi));
            assign rd_byte[gi] = dbus_rdata[8*gi +: 8];
        end
    endgenerate

    assign be_req    = is_word ? 4'b1111 : (is_half ? (offs[1] ? 4'b1100 : 4'b0011) : be_byte);
    assign wdata_req = is_word ? ex_store_data
                     : (is_half ? {2{ex_store_data[15:0]}} : {4{ex_store_data[7:0]}});

    assign sel_byte = rd_byte[offs_reg];
    assign sel_half = offs_reg[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    always_comb begin
        load_data = dbus_rdata;
        if (!op_reg[1]) begin
            if (op_reg[0]) load_data = {{16{sel_half[15] & ~op_reg[2]}}, sel_half};
            else           load_data = {{24{sel_byte[7] & ~op_reg[2]}}, sel_byte};
        end
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || state_reg != BUS) tmo_cnt_reg <= '0;
        else                         tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
    end
    // Counter reads TIMEOUT-1 during the TIMEOUT-th cycle spent in BUS
    assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        dbus_we_next    = dbus_we_reg;
        dbus_addr_next  = dbus_addr_reg;
        dbus_be_next    = dbus_be_reg;
        dbus_wdata_next = dbus_wdata_reg;
        wb_valid_next   = 1'b0;
        wb_waddr_next   = wb_waddr_reg;
        wb_we_next      = wb_we_reg;
        wb_wdata_next   = wb_wdata_reg;
        misalign_next   = 1'b0;
        bus_err_next    = 1'b0;
        op_next         = op_reg;
        offs_next       = offs_reg;
        pend_waddr_next = pend_waddr_reg;
        pend_we_next    = pend_we_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_next = 1'b1;
                        wb_waddr_next = ex_reg_waddr;
                        wb_we_next    = ex_reg_we;
                        wb_wdata_next = ex_reg_wdata;
                    end else if (misaligned) begin
                        wb_valid_next = 1'b1;
                        wb_waddr_next = ex_reg_waddr;
                        wb_we_next    = 1'b0;
                        wb_wdata_next = ex_reg_wdata;
                        misalign_next = 1'b1;
                    end else begin
                        state_next      = BUS;
                        dbus_we_next    = is_store;
                        dbus_addr_next  = {addr[ADDR_W-1:2], 2'b00};
                        dbus_be_next    = be_req;
                        dbus_wdata_next = wdata_req;
                        op_next         = ex_mem_op;
                        offs_next       = offs;
                        pend_waddr_next = ex_reg_waddr;
                        pend_we_next    = ex_reg_we & ~is_store;
                    end
                end
            end
            BUS: begin
                // An ack in the timeout cycle wins over the timeout
                if (dbus_ack) begin
                    state_next    = IDLE;
                    wb_valid_next = 1'b1;
                    wb_waddr_next = pend_waddr_reg;
                    wb_we_next    = pend_we_reg;
                    wb_wdata_next = dbus_we_reg ? 32'd0 : load_data;
                end else if (tmo_hit) begin
                    state_next    = IDLE;
                    wb_valid_next = 1'b1;
                    wb_waddr_next = pend_waddr_reg;
                    wb_we_next    = 1'b0;
                    wb_wdata_next = 32'd0;
                    bus_err_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            dbus_we_reg    <= 1'b0;
            dbus_addr_reg  <= '0;
            dbus_be_reg    <= 4'd0;
            dbus_wdata_reg <= 32'd0;
            wb_valid_reg   <= 1'b0;
            wb_waddr_reg   <= 5'd0;
            wb_we_reg      <= 1'b0;
            wb_wdata_reg   <= 32'd0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
            op_reg         <= 3'd0;
            offs_reg       <= 2'd0;
            pend_waddr_reg <= 5'd0;
            pend_we_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dbus_we_reg    <= dbus_we_next;
            dbus_addr_reg  <= dbus_addr_next;
            dbus_be_reg    <= dbus_be_next;
            dbus_wdata_reg <= dbus_wdata_next;
            wb_valid_reg   <= wb_valid_next;
            wb_waddr_reg   <= wb_waddr_next;
            wb_we_reg      <= wb_we_next;
            wb_wdata_reg   <= wb_wdata_next;
            misalign_reg   <= misalign_next;
            bus_err_reg    <= bus_err_next;
            op_reg         <= op_next;
            offs_reg       <= offs_next;
            pend_waddr_reg <= pend_waddr_next;
            pend_we_reg    <= pend_we_next;
        end
    end

    assign dbus_req     = (state_reg == BUS);
    assign dbus_we      = dbus_we_reg;
    assign dbus_addr    = dbus_addr_reg;
    assign dbus_be      = dbus_be_reg;
    assign dbus_wdata   = dbus_wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_reg_waddr = wb_waddr_reg;
    assign wb_reg_we    = wb_we_reg;
    assign wb_reg_wdata = wb_wdata_reg;
    assign misalign_o   = misalign_reg;
    assign bus_err_o    = bus_err_reg;
endmodule

// File: tb/tb_lsu_mem.sv
// Scoreboard bench for lsu_mem: directed cases plus random traffic, a bus responder and a writeback monitor.
module tb_lsu_mem;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_ready, ex_reg_we, ex_mem_rd, ex_mem_wr;
    logic [4:0]  ex_reg_waddr;
    logic [31:0] ex_reg_wdata, ex_store_data;
    logic [2:0]  ex_mem_op;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        wb_valid, wb_reg_we, misalign_o, bus_err_o;
    logic [4:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;

    always #5 clk = ~clk;

    lsu_mem #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_waddr(ex_reg_waddr), .ex_reg_we(ex_reg_we), .ex_reg_wdata(ex_reg_wdata),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_op(ex_mem_op),
        .ex_store_data(ex_store_data), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .wb_valid(wb_valid),
        .wb_reg_waddr(wb_reg_waddr), .wb_reg_we(wb_reg_we), .wb_reg_wdata(wb_reg_wdata),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic        chk_data;
        logic        mis;
        logic        berr;
        int          kind;   // 0: T+1, 1: ack+1, 2: T+1+TIMEOUT
        int          acc;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          wait_n; // negative: never ack
        logic [31:0] rdata;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    int   cyc = 0;
    int   last_ack_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] op, input logic [31:0] a);
        int sz = size_of(op);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] store_of(input logic [2:0] op, input logic [31:0] sd);
        int sz = size_of(op);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        int     sz = size_of(op);
        int     sh = 8 * int'(a % 4);
        longint v;
        v = longint'({32'd0, rd >> sh});
        v = v & ((longint'(1) << (8 * sz)) - 1);
        if (op < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    // mode 0: normal, 1: no ack and no writeback (reset abort), 2: no ack, timeout writeback
    task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] wa,
                         input logic we, input int wait_n, input logic [31:0] rdat, input int mode);
        int   n;
        int   sz;
        bit   mem, mis;
        wb_t  w;
        bus_t b;
        n = 0;
        while (!ex_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ex_ready) begin
            chk("ready_wait", ex_ready, 1);
            return;
        end
        ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr; ex_mem_op = op;
        ex_reg_wdata = a; ex_store_data = sd; ex_reg_waddr = wa; ex_reg_we = we;
        mem = rd | wr;
        sz  = size_of(op);
        mis = mem && ((a % sz) != 0);
        w.waddr = wa; w.we = we; w.wdata = a; w.chk_data = 1'b1;
        w.mis = 1'b0; w.berr = 1'b0; w.kind = 0; w.acc = cyc;
        if (mem) begin
            if (mis) begin
                w.we = 1'b0; w.mis = 1'b1; w.chk_data = 1'b0;
            end else begin
                b.addr = a & ~32'h3; b.we = wr; b.be = be_of(op, a);
                b.wdata = store_of(op, sd); b.wait_n = (mode == 0) ? wait_n : -1;
                b.rdata = rdat;
                bus_q.push_back(b);
                w.kind = (mode == 2) ? 2 : 1;
                if (wr) begin
                    w.we = 1'b0; w.chk_data = 1'b0;
                end else begin
                    w.wdata = load_fmt(op, a, rdat);
                end
                if (mode == 2) begin
                    w.we = 1'b0; w.berr = 1'b1; w.chk_data = 1'b0;
                end
            end
        end
        if (mode != 1) wb_q.push_back(w);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_mem_rd = 1'($urandom); ex_mem_wr = 1'($urandom);
        ex_reg_wdata = $urandom; ex_store_data = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Bus responder
    initial begin
        bus_t b;
        int   n;
        dbus_ack = 1'b0;
        dbus_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (dbus_req && !rst) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", dbus_req, 0);
                    dbus_ack = 1'b1; dbus_rdata = $urandom;
                    @(posedge clk); #1;
                    dbus_ack = 1'b0;
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", dbus_addr, b.addr);
                    chk("bus_we", dbus_we, b.we);
                    chk("bus_be", dbus_be, b.be);
                    if (b.we) chk("bus_wdata", dbus_wdata, b.wdata);
                    if (b.wait_n < 0) begin
                        n = 0;
                        while (dbus_req && n < 400) begin
                            @(posedge clk); #1;
                            n++;
                        end
                        chk("bus_req_drop", dbus_req, 0);
                        // late ack while idle must be ignored
                        dbus_ack = 1'b1; dbus_rdata = $urandom;
                        @(posedge clk); #1;
                        dbus_ack = 1'b0;
                    end else begin
                        repeat (b.wait_n) begin
                            @(posedge clk); #1;
                        end
                        chk("bus_hold_req", dbus_req, 1);
                        chk("bus_hold_addr", dbus_addr, b.addr);
                        chk("bus_hold_be", dbus_be, b.be);
                        dbus_ack = 1'b1; dbus_rdata = b.rdata; last_ack_cyc = cyc;
                        @(posedge clk); #1;
                        dbus_ack = 1'b0; dbus_rdata = $urandom;
                        chk("bus_req_after_ack", dbus_req, 0);
                    end
                end
            end
        end
    end

    // Writeback monitor
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst) chk("ex_ready_vs_req", ex_ready, !dbus_req);
            chk("stray_flag", (misalign_o | bus_err_o) & ~wb_valid, 0);
            if (wb_valid) begin
                $display("wb cyc=%0d x%0d we=%0b data=%08h mis=%0b err=%0b",
                         cyc, wb_reg_waddr, wb_reg_we, wb_reg_wdata, misalign_o, bus_err_o);
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_waddr", wb_reg_waddr, e.waddr);
                    chk("wb_we", wb_reg_we, e.we);
                    chk("wb_misalign", misalign_o, e.mis);
                    chk("wb_bus_err", bus_err_o, e.berr);
                    if (e.chk_data) chk("wb_wdata", wb_reg_wdata, e.wdata);
                    case (e.kind)
                        0:       chk("wb_latency", cyc, e.acc + 1);
                        1:       chk("wb_after_ack", cyc, last_ack_cyc + 1);
                        default: chk("wb_timeout_latency", cyc, e.acc + 1 + TIMEOUT);
                    endcase
                end
            end
        end
    end

    initial begin
        int n;
        int kind;
        logic rd, wr;
        ex_valid = 1'b0; ex_reg_waddr = 5'd0; ex_reg_we = 1'b0; ex_reg_wdata = 32'd0;
        ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_mem_op = 3'd0; ex_store_data = 32'd0;
        idle(3);
        rst = 1'b0;
        #1;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_dbus_req", dbus_req, 0);
        chk("rst_dbus_we", dbus_we, 0);
        chk("rst_dbus_addr", dbus_addr, 0);
        chk("rst_dbus_be", dbus_be, 0);
        chk("rst_dbus_wdata", dbus_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_fields", {wb_reg_waddr, wb_reg_we, wb_reg_wdata}, 0);
        chk("rst_flags", {misalign_o, bus_err_o}, 0);
        idle(1);

        for (int i = 1; i <= 4; i++) begin
            chk("alu_stream_ready", ex_ready, 1);
            issue(1'b0, 1'b0, 3'b110, 32'h100 + 32'(i), 32'd0, 5'(i), 1'b1, 0, 32'd0, 0);
        end
        idle(2);
        issue(1'b1, 1'b0, 3'b000, 32'h1003, 32'd0, 5'd5, 1'b1, 3, 32'h80FF_1234, 0);
        issue(1'b1, 1'b0, 3'b101, 32'h2002, 32'd0, 5'd6, 1'b1, 1, 32'hBEEF_0000, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h2004, 32'd0, 5'd7, 1'b1, 0, 32'h1234_5678, 0);
        issue(1'b0, 1'b1, 3'b000, 32'h0001, 32'h1234_56A5, 5'd8, 1'b1, 2, 32'd0, 0);
        issue(1'b0, 1'b1, 3'b010, 32'h1002, 32'hCAFE_F00D, 5'd9, 1'b1, 0, 32'd0, 0);
        idle(3);

        issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'd0, 5'd10, 1'b1, 0, 32'd0, 1);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_req_drop", dbus_req, 0);
        chk("rst_mid_no_wb", wb_valid, 0);
        rst = 1'b0;
        idle(4);

`ifdef LSU_BUS_TIMEOUT_EN
        issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'd0, 5'd11, 1'b1, 0, 32'd0, 2);
        idle(TIMEOUT + 4);
        chk("timeout_ready_back", ex_ready, 1);
`endif

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            rd = (kind >= 4 && kind <= 6) || kind == 9;
            wr = (kind >= 7);
            issue(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                  1'($urandom), $urandom_range(0, 4), $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        n = 0;
        while ((wb_q.size() != 0 || bus_q.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        idle(3);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
# lsu_mem

Memory-access stage of the Eriscv integer pipeline, placed directly downstream of the execute stage. For ALU instructions it registers the execute result toward writeback with one-cycle latency. For loads and stores it uses the execute result as the effective address, runs one data-bus transaction with a req/ack handshake, and formats load data (byte or halfword select, sign or zero extension). It stalls the execute stage with `ex_ready` while a transaction is outstanding.

## Interface
- `ADDR_W`, 32, data-bus address width; `ex_reg_wdata[ADDR_W-1:0]` supplies the effective address.
- `TIMEOUT`, 256, ack-wait limit in cycles; used only with `LSU_BUS_TIMEOUT_EN`.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `ex_valid`  in  1  execute result valid this cycle
- `ex_ready`  out  1  stage accepts; high only in IDLE
- `ex_reg_waddr`  in  5  destination register
- `ex_reg_we`  in  1  register write enable
- `ex_reg_wdata`  in  32  ALU result, or effective address for memory ops
- `ex_mem_rd`  in  1  instruction is a load
- `ex_mem_wr`  in  1  instruction is a store
- `ex_mem_op`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `ex_store_data`  in  32  rs2 value for stores
- `dbus_req`  out  1  transaction request
- `dbus_we`  out  1  1 = write
- `dbus_addr`  out  ADDR_W  word-aligned address, low 2 bits = 0
- `dbus_be`  out  4  byte enables
- `dbus_wdata`  out  32  lane-replicated store data
- `dbus_ack`  in  1  transaction complete; `dbus_rdata` valid in the same cycle
- `dbus_rdata`  in  32  read word
- `wb_valid`  out  1  one-cycle pulse per retired instruction
- `wb_reg_waddr`  out  5  writeback address
- `wb_reg_we`  out  1  writeback enable
- `wb_reg_wdata`  out  32  writeback data
- `misalign_o`  out  1  one-cycle pulse when a misaligned access is dropped
- `bus_err_o`  out  1  one-cycle pulse on bus timeout

## Operation
- **FSM states:** IDLE and BUS.
- **Accept:** an instruction is accepted when `ex_valid && ex_ready`.
- **Non-memory instruction:**
  - Outputs are registered: `wb_valid`=1 and `wb_reg_*` = `ex_reg_*`.
  - State stays IDLE.
- **Memory instruction:**
  - If `ex_mem_rd` and `ex_mem_wr` are both high, the instruction is treated as a store.
  - **Misaligned access:** H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
    - No bus transaction is issued.
    - `wb_valid`=1, `wb_reg_we`=0, `misalign_o`=1.
  - **Aligned access:** go to BUS and register the bus fields.
    - `dbus_addr` = {addr[ADDR_W-1:2], 2'b00}.
    - SB: `be` = 1<<addr[1:0], `wdata` = {4{byte}}.
    - SH: `be` = 0011 or 1100, `wdata` = {2{half}}.
    - SW: `be` = 1111.
    - Loads: `be` follows the same size rule, `dbus_we`=0.
- **BUS state:**
  - `dbus_req`=1, and `addr`/`we`/`be`/`wdata` hold stable until ack.
  - On `dbus_ack`: register writeback and return to IDLE.
  - Load: the byte or half selected by addr[1:0] is sign-extended (B/H) or zero-extended (BU/HU); W passes through.
  - Store: `wb_reg_we` is forced to 0.
- **`ex_mem_op` codes 011, 110, 111:** treated as W.
- **Reset values:** all outputs 0 and state IDLE, except `ex_ready`=1 once `rst` is low.

## Timing
- **Accept cycle:** call it T.
- **ALU instruction:** `wb_valid` in T+1. Back-to-back issue is sustained at 1 per cycle.
- **Memory instruction:**
  - `dbus_req` from T+1.
  - Ack at T+k (k≥1) gives `wb_valid` and `req`=0 at T+k+1.
  - The next accept is possible at T+k+1.
- **Zero-wait load:** ack in T+1 gives `wb_valid` at T+2.
- **Misaligned access:** `wb_valid` and `misalign_o` in T+1, with no stall.
- **`ex_ready`:** 0 for every cycle in BUS, including the ack cycle.
- **Ack while in IDLE:** ignored.
- **Reset mid-transaction:** `rst` high at the edge returns the stage to IDLE and drops `dbus_req` the next cycle. No `wb_valid` is produced; a late ack is ignored.
- **`wb_valid`:** never high for two consecutive cycles from a single instruction.

## Configuration
- **Macro:** `LSU_BUS_TIMEOUT_EN`.
- **Defined:**
  - An 8+-bit counter runs in BUS.
  - If ack is still absent after `TIMEOUT` cycles in BUS, the stage drops `dbus_req` and returns to IDLE.
  - The next cycle produces `wb_valid`=1, `wb_reg_we`=0 and `bus_err_o`=1.
  - An ack arriving in the timeout cycle takes priority over the timeout.
- **Undefined:** BUS waits indefinitely and `bus_err_o` is tied to 0.

## Test plan
- **ALU streaming:** ORI results to x1..x4 issued on 4 consecutive cycles -> `wb_valid` on 4 consecutive cycles, data matches, `ex_ready` stays 1.
- **LB sign extension:** LB from addr 0x1003, ack after 3 wait cycles, rdata 0x80FF_1234 -> `be`=1000, `addr`=0x1000, `wb_reg_wdata`=0xFFFF_FF80, `ex_ready` low for 4 cycles.
- **LHU zero extension:** LHU from 0x2002, rdata 0xBEEF_0000 -> 0x0000_BEEF. LW zero-wait -> `wb_valid` at T+2.
- **SB to address 0x01:** SB 0x...A5 to 0x01 -> `be`=0010, `wdata`=0xA5A5A5A5, `we`=1, `wb_reg_we`=0.
- **Misaligned and reset cases:**
  - SW to 0x1002 -> no `dbus_req`, `misalign_o` pulse, `wb_reg_we`=0.
  - `rst` asserted in BUS -> `req`=0 next cycle, no `wb_valid`.
- **Timeout (with `LSU_BUS_TIMEOUT_EN`):** load with no ack -> `bus_err_o` pulse after 256 cycles, `ex_ready` returns to 1.
